// File: rtl/c16_mem_arbiter.sv
// Shares one external memory port between the C16 bus and a host image loader.
// C16 cycles win; loader writes fill the gaps and stall the CPU only on collision.
module c16_mem_arbiter #(
    parameter int              AW        = 18,
    parameter logic [AW-1:0]   ROM0_BASE = 18'h20000,
    parameter logic [AW-1:0]   ROM1_BASE = 18'h28000,
    parameter int              TIMEOUT   = 15
) (
    input  logic          CLK28,
    input  logic          RESET_N,
    input  logic          c16_strobe,
    input  logic [15:0]   c16_addr,
    input  logic [7:0]    c16_dout,
    input  logic          c16_rnw,
    input  logic          cs_ram,
    input  logic          cs0,
    input  logic          cs1,
    output logic [7:0]    c16_din,
    output logic          WAIT,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          ld_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ready,
    output logic          err
);

    typedef enum logic [1:0] {IDLE = 2'd0, C16 = 2'd1, LD = 2'd2} state_t;

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic          req_nxt, we_nxt, ack_nxt, wait_nxt, err_nxt;
    logic [AW-1:0] addr_nxt;
    logic [7:0]    wdata_nxt;
    logic          pending, pending_nxt;
    logic          rd_valid, rd_valid_nxt;
    logic [7:0]    rd_data, rd_data_nxt;
    logic [AW-1:0] cap_addr, cap_addr_nxt;
    logic          cap_we, cap_we_nxt;
    logic [7:0]    cap_wdata, cap_wdata_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic          cs_any, need_mem, expired;
    logic [AW-1:0] map_addr;

    always_comb begin
        cs_any   = cs_ram | cs0 | cs1;
        // ROM windows are read-only: a ROM write never reaches memory
        need_mem = cs_any & (cs_ram | c16_rnw);
        expired  = (cnt == CNT_LAST);
        if (cs_ram)
            map_addr = {{(AW-16){1'b0}}, c16_addr};
        else if (cs0)
            map_addr = ROM0_BASE | {{(AW-15){1'b0}}, c16_addr[14:0]};
        else
            map_addr = ROM1_BASE | {{(AW-15){1'b0}}, c16_addr[14:0]};
    end

    always_comb begin
        state_nxt     = state;
        req_nxt       = mem_req;
        we_nxt        = mem_we;
        addr_nxt      = mem_addr;
        wdata_nxt     = mem_wdata;
        ack_nxt       = 1'b0;
        wait_nxt      = WAIT;
        err_nxt       = err;
        pending_nxt   = pending;
        rd_valid_nxt  = rd_valid;
        rd_data_nxt   = rd_data;
        cap_addr_nxt  = cap_addr;
        cap_we_nxt    = cap_we;
        cap_wdata_nxt = cap_wdata;
        cnt_nxt       = cnt;

        unique case (state)
            IDLE: begin
                if (c16_strobe)
                    rd_valid_nxt = 1'b0;
                if (pending) begin
                    state_nxt = C16;
                    req_nxt   = 1'b1;
                    we_nxt    = cap_we;
                    addr_nxt  = cap_addr;
                    wdata_nxt = cap_wdata;
                    cnt_nxt   = '0;
                end else if (c16_strobe && need_mem) begin
                    state_nxt = C16;
                    req_nxt   = 1'b1;
                    we_nxt    = ~c16_rnw;
                    addr_nxt  = map_addr;
                    wdata_nxt = c16_dout;
                    cnt_nxt   = '0;
                // ld_req is still high during the ack cycle; don't replay that write
                end else if (ld_req && !ld_ack) begin
                    state_nxt = LD;
                    req_nxt   = 1'b1;
                    we_nxt    = 1'b1;
                    addr_nxt  = ld_addr;
                    wdata_nxt = ld_data;
                    cnt_nxt   = '0;
                end
            end
            C16: begin
                if (mem_ready || expired) begin
                    state_nxt    = IDLE;
                    req_nxt      = 1'b0;
                    pending_nxt  = 1'b0;
                    wait_nxt     = 1'b0;
                    err_nxt      = err | ~mem_ready;
                    if (!mem_we) begin
                        rd_valid_nxt = 1'b1;
                        rd_data_nxt  = mem_ready ? mem_rdata : 8'hFF;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            LD: begin
                if (c16_strobe) begin
                    rd_valid_nxt = 1'b0;
                    if (need_mem) begin
                        pending_nxt   = 1'b1;
                        wait_nxt      = 1'b1;
                        cap_addr_nxt  = map_addr;
                        cap_we_nxt    = ~c16_rnw;
                        cap_wdata_nxt = c16_dout;
                    end
                end
                if (mem_ready || expired) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                    ack_nxt   = 1'b1;
                    err_nxt   = err | ~mem_ready;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK28) begin
        if (!RESET_N) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ld_ack    <= 1'b0;
            WAIT      <= 1'b0;
            err       <= 1'b0;
            pending   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= 8'hFF;
            cap_addr  <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            ld_ack    <= ack_nxt;
            WAIT      <= wait_nxt;
            err       <= err_nxt;
            pending   <= pending_nxt;
            rd_valid  <= rd_valid_nxt;
            rd_data   <= rd_data_nxt;
            cap_addr  <= cap_addr_nxt;
            cap_we    <= cap_we_nxt;
            cap_wdata <= cap_wdata_nxt;
            cnt       <= cnt_nxt;
        end
    end

    assign c16_din = rd_valid ? rd_data : 8'hFF;

endmodule

// File: tb/tb_c16_mem_arbiter.sv
// Bench for c16_mem_arbiter: directed scenarios, then random traffic checked
// against a byte-array memory image updated in request order.
module tb_c16_mem_arbiter;

    logic        CLK28 = 1'b0;
    logic        RESET_N = 1'b0;
    logic        c16_strobe = 1'b0;
    logic [15:0] c16_addr = '0;
    logic [7:0]  c16_dout = '0;
    logic        c16_rnw = 1'b1;
    logic        cs_ram = 1'b0, cs0 = 1'b0, cs1 = 1'b0;
    logic [7:0]  c16_din;
    logic        WAIT;
    logic        ld_req = 1'b0;
    logic [17:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        ld_ack;
    logic        mem_req, mem_we;
    logic [17:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        err;

    int errors = 0;
    int checks = 0;

    c16_mem_arbiter dut (
        .CLK28(CLK28), .RESET_N(RESET_N), .c16_strobe(c16_strobe), .c16_addr(c16_addr),
        .c16_dout(c16_dout), .c16_rnw(c16_rnw), .cs_ram(cs_ram), .cs0(cs0), .cs1(cs1),
        .c16_din(c16_din), .WAIT(WAIT), .ld_req(ld_req), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_ack(ld_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .err(err)
    );

    always #5 CLK28 = ~CLK28;

    // Memory responder: answers each request after resp_lat request cycles
    logic [7:0] phys    [0:262143];
    logic [7:0] ref_mem [0:262143];
    int resp_lat = 2;
    int wcnt = 0;
    int acc_cnt = 0;

    always begin
        @(posedge CLK28);
        #2;
        if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (mem_req) begin
            wcnt++;
            if (wcnt >= resp_lat) begin
                if (mem_we) phys[mem_addr] = mem_wdata;
                else        mem_rdata = phys[mem_addr];
                mem_ready = 1'b1;
                wcnt = 0;
                acc_cnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge CLK28);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_strobe(input logic r, input logic c0, input logic c1,
                                input logic [15:0] a, input logic rd, input logic [7:0] d);
        c16_strobe = 1'b1; cs_ram = r; cs0 = c0; cs1 = c1;
        c16_addr = a; c16_rnw = rd; c16_dout = d;
        tick();
        c16_strobe = 1'b0; cs_ram = 1'b0; cs0 = 1'b0; cs1 = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (mem_req === 1'b1) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (ld_ack === 1'b1) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            if (acc_cnt >= target && mem_req === 1'b0) ok = 1'b1;
            else tick();
        end
    endtask

    function automatic logic [17:0] ref_map(input int sel, input logic [15:0] a);
        int ai;
        int v;
        ai = int'(a);
        if (sel == 0)      v = ai;
        else if (sel == 1) v = 'h20000 + (ai % 'h8000);
        else               v = 'h28000 + (ai % 'h8000);
        return v[17:0];
    endfunction

    initial begin
        int base, nreq, sel, lsel, kind, nbad;
        bit ok, seen, anyreq, anywait, anyack;
        logic [15:0] pa;
        logic [17:0] ma, la;
        logic [7:0]  d, ld, exp_rd;
        logic        rd;

        for (int i = 0; i < 262144; i++) phys[i] = 8'(i) ^ 8'h3C;

        // power-on reset
        repeat (3) tick();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_c16_din", 32'(c16_din), 'hFF);
        chk("rst_wait", 32'(WAIT), 0);
        chk("rst_ld_ack", 32'(ld_ack), 0);
        chk("rst_err", 32'(err), 0);

        // reset in the middle of a loader write
        RESET_N = 1'b1;
        resp_lat = 100;
        ld_req = 1'b1; ld_addr = 18'h15555; ld_data = 8'hC3;
        wait_req(ok);
        chk("ld_req_rise", 32'(ok), 1);
        chk("ld_mem_we", 32'(mem_we), 1);
        chk("ld_mem_addr", 32'(mem_addr), 'h15555);
        chk("ld_mem_wdata", 32'(mem_wdata), 'hC3);
        RESET_N = 1'b0;
        anyack = 1'b0;
        repeat (3) begin
            tick();
            if (ld_ack) anyack = 1'b1;
        end
        chk("midrst_mem_req", 32'(mem_req), 0);
        chk("midrst_c16_din", 32'(c16_din), 'hFF);
        chk("midrst_wait", 32'(WAIT), 0);
        chk("midrst_no_ack", 32'(anyack), 0);
        chk("midrst_err", 32'(err), 0);
        ld_req = 1'b0;
        RESET_N = 1'b1;
        tick(); tick();

        // unloaded RAM read
        phys[18'h01234] = 8'h5A;
        resp_lat = 3;
        pulse_strobe(1, 0, 0, 16'h1234, 1, 8'h00);
        chk("ram_rd_req", 32'(mem_req), 1);
        chk("ram_rd_addr", 32'(mem_addr), 'h01234);
        chk("ram_rd_we", 32'(mem_we), 0);
        chk("ram_rd_din_early", 32'(c16_din), 'hFF);
        chk("ram_rd_wait", 32'(WAIT), 0);
        nreq = 1; ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            if (mem_req === 1'b0) ok = 1'b1;
            else nreq++;
        end
        chk("ram_rd_done", 32'(ok), 1);
        chk("ram_rd_req_len", 32'(nreq), 3);
        chk("ram_rd_din", 32'(c16_din), 'h5A);
        pulse_strobe(0, 0, 0, 16'h0000, 1, 8'h00);
        chk("strobe_clears_din", 32'(c16_din), 'hFF);
        chk("nocs_no_req", 32'(mem_req), 0);

        // ROM map, chip-select priority, ROM write drop
        phys[18'h2C123] = 8'h3C;
        resp_lat = 2;
        base = acc_cnt;
        pulse_strobe(0, 0, 1, 16'hC123, 1, 8'h00);
        chk("rom1_req", 32'(mem_req), 1);
        chk("rom1_addr", 32'(mem_addr), 'h2C123);
        wait_done(base + 1, ok);
        chk("rom1_done", 32'(ok), 1);
        chk("rom1_din", 32'(c16_din), 'h3C);
        phys[18'h08123] = 8'h81;
        base = acc_cnt;
        pulse_strobe(1, 0, 1, 16'h8123, 1, 8'h00);
        chk("cs_priority_addr", 32'(mem_addr), 'h08123);
        wait_done(base + 1, ok);
        chk("cs_priority_din", 32'(c16_din), 'h81);
        base = acc_cnt;
        pulse_strobe(0, 1, 0, 16'h4567, 0, 8'hEE);
        anyreq = 1'b0; anywait = 1'b0;
        repeat (4) begin
            if (mem_req) anyreq = 1'b1;
            if (WAIT) anywait = 1'b1;
            tick();
        end
        chk("rom_wr_no_req", 32'(anyreq), 0);
        chk("rom_wr_no_wait", 32'(anywait), 0);
        chk("rom_wr_no_access", 32'(acc_cnt - base), 0);

        // C16 write collides with an in-flight loader write
        resp_lat = 4;
        base = acc_cnt;
        ld_req = 1'b1; ld_addr = 18'h10000; ld_data = 8'hAA;
        wait_req(ok);
        chk("coll_ld_req", 32'(ok), 1);
        chk("coll_ld_addr", 32'(mem_addr), 'h10000);
        pulse_strobe(1, 0, 0, 16'h0300, 0, 8'h77);
        chk("coll_wait_set", 32'(WAIT), 1);
        chk("coll_still_ld", 32'(mem_addr), 'h10000);
        wait_ack(seen);
        chk("coll_ack", 32'(seen), 1);
        chk("coll_ack_first", 32'(acc_cnt - base), 1);
        chk("coll_wait_held", 32'(WAIT), 1);
        chk("coll_ld_written", 32'(phys[18'h10000]), 'hAA);
        ld_req = 1'b0;
        tick();
        chk("coll_c16_req", 32'(mem_req), 1);
        chk("coll_c16_addr", 32'(mem_addr), 'h00300);
        chk("coll_c16_we", 32'(mem_we), 1);
        chk("coll_c16_wdata", 32'(mem_wdata), 'h77);
        wait_done(base + 2, ok);
        chk("coll_c16_done", 32'(ok), 1);
        chk("coll_wait_clr", 32'(WAIT), 0);
        chk("coll_c16_written", 32'(phys[18'h00300]), 'h77);

        // strobe and ld_req in the same idle cycle
        resp_lat = 2;
        base = acc_cnt;
        ld_req = 1'b1; ld_addr = 18'h00055; ld_data = 8'h11;
        pulse_strobe(1, 0, 0, 16'h0300, 1, 8'h00);
        chk("simul_c16_first", 32'(mem_addr), 'h00300);
        chk("simul_c16_rd", 32'(mem_we), 0);
        wait_ack(seen);
        chk("simul_ack", 32'(seen), 1);
        chk("simul_ack_after_two", 32'(acc_cnt - base), 2);
        chk("simul_din", 32'(c16_din), 'h77);
        ld_req = 1'b0;
        tick();
        chk("simul_ld_written", 32'(phys[18'h00055]), 'h11);

        // read that never completes
        resp_lat = 1000;
        base = acc_cnt;
        pulse_strobe(1, 0, 0, 16'h0400, 1, 8'h00);
        nreq = 0; ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (mem_req === 1'b0) ok = 1'b1;
            else begin nreq++; tick(); end
        end
        chk("to_drop", 32'(ok), 1);
        chk("to_req_len", 32'(nreq), 15);
        chk("to_err", 32'(err), 1);
        chk("to_din", 32'(c16_din), 'hFF);
        chk("to_wait", 32'(WAIT), 0);
        chk("to_no_access", 32'(acc_cnt - base), 0);
        repeat (3) tick();
        chk("to_err_sticky", 32'(err), 1);
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();
        chk("to_err_cleared", 32'(err), 0);

        // random traffic against the byte-array image
        for (int i = 0; i < 262144; i++) ref_mem[i] = phys[i];
        for (int it = 0; it < 48; it++) begin
            kind = int'($urandom_range(0, 3));
            resp_lat = int'($urandom_range(2, 5));
            sel = int'($urandom_range(0, 2));
            pa = 16'h0100 + 16'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) pa = pa + 16'h8000;
            rd = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            ma = ref_map(sel, pa);
            lsel = int'($urandom_range(0, 2));
            la = ref_map(lsel, 16'h0100 + 16'($urandom_range(0, 7)));
            ld = 8'($urandom);
            base = acc_cnt;
            if (kind >= 2 && sel != 0) rd = 1'b1;

            if (kind == 0) begin
                if (!rd && sel != 0) begin
                    pulse_strobe(0, sel == 1, sel == 2, pa, rd, d);
                    anyreq = 1'b0;
                    repeat (3) begin
                        if (mem_req) anyreq = 1'b1;
                        tick();
                    end
                    chk("rnd_rom_wr_drop", 32'(anyreq), 0);
                end else begin
                    exp_rd = ref_mem[ma];
                    if (!rd) ref_mem[ma] = d;
                    pulse_strobe(sel == 0, sel == 1, sel == 2, pa, rd, d);
                    chk("rnd_c16_addr", 32'(mem_addr), 32'(ma));
                    wait_done(base + 1, ok);
                    chk("rnd_c16_done", 32'(ok), 1);
                    chk("rnd_c16_no_wait", 32'(WAIT), 0);
                    if (rd) chk("rnd_c16_rd", 32'(c16_din), 32'(exp_rd));
                end
            end else if (kind == 1) begin
                ref_mem[la] = ld;
                ld_req = 1'b1; ld_addr = la; ld_data = ld;
                wait_ack(seen);
                chk("rnd_ld_ack", 32'(seen), 1);
                ld_req = 1'b0;
            end else if (kind == 2) begin
                ld_req = 1'b1; ld_addr = la; ld_data = ld;
                wait_req(ok);
                chk("rnd_coll_ld_req", 32'(ok), 1);
                ref_mem[la] = ld;
                exp_rd = ref_mem[ma];
                if (!rd) ref_mem[ma] = d;
                pulse_strobe(sel == 0, sel == 1, sel == 2, pa, rd, d);
                chk("rnd_coll_wait", 32'(WAIT), 1);
                wait_ack(seen);
                chk("rnd_coll_ack", 32'(seen), 1);
                ld_req = 1'b0;
                wait_done(base + 2, ok);
                chk("rnd_coll_done", 32'(ok), 1);
                chk("rnd_coll_wait_clr", 32'(WAIT), 0);
                if (rd) chk("rnd_coll_rd", 32'(c16_din), 32'(exp_rd));
            end else begin
                exp_rd = ref_mem[ma];
                if (!rd) ref_mem[ma] = d;
                ref_mem[la] = ld;
                ld_req = 1'b1; ld_addr = la; ld_data = ld;
                pulse_strobe(sel == 0, sel == 1, sel == 2, pa, rd, d);
                chk("rnd_simul_addr", 32'(mem_addr), 32'(ma));
                wait_ack(seen);
                chk("rnd_simul_ack", 32'(seen), 1);
                chk("rnd_simul_order", 32'(acc_cnt - base), 2);
                ld_req = 1'b0;
                if (rd) chk("rnd_simul_rd", 32'(c16_din), 32'(exp_rd));
            end
            tick();
        end

        tick(); tick();
        nbad = 0;
        for (int i = 0; i < 262144; i++)
            if (ref_mem[i] !== phys[i]) nbad++;
        chk("mem_image", 32'(nbad), 0);
        chk("final_err", 32'(err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
